// File: rtl/obi_mem_responder_pkg.sv
// Shared types and constants for the OBI memory responder.
// Contents: OBI request/response payloads, pipeline stage record,
// error read pattern, stall LFSR seed and the latency ceiling.
package obi_mem_responder_pkg;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned BE_W        = DATA_W / 8;
  localparam int unsigned LFSR_W      = 16;
  localparam int unsigned MAX_LATENCY = 4;

  localparam logic [DATA_W-1:0] RD_ERR_PATTERN = 32'hBADC_AB1E;
  localparam logic [LFSR_W-1:0] LFSR_SEED      = 16'hACE1;

  typedef struct packed {
    logic              req;
    logic              we;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
  } obi_resp_t;

  // One slot of the fixed-latency response pipeline.
  typedef struct packed {
    logic              valid;
    logic              err;
    logic [DATA_W-1:0] rdata;
  } resp_stage_t;

endpackage

// File: rtl/obi_mem_responder_if.sv
// OBI bus bundle between a master and the memory responder.
// Signals: req_i (request payload), resp_o (gnt/rvalid/rdata), err_o
// (out-of-range flag, coincident with rvalid).
interface obi_mem_responder_if;
  import obi_mem_responder_pkg::*;

  obi_req_t  req_i;
  obi_resp_t resp_o;
  logic      err_o;

  modport slave  (input  req_i, output resp_o, output err_o);
  modport master (output req_i, input  resp_o, input  err_o);
endinterface

// File: rtl/obi_mem_responder_lfsr.sv
// Random grant-stall generator: 16-bit Fibonacci LFSR (taps 16,14,13,11),
// seeded on reset, advancing every cycle; stall when the low two bits are 0.
// Ports: clk_i, rst_i (sync, active-high), stall_o.
module obi_mem_responder_lfsr
  import obi_mem_responder_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  output logic stall_o
);

  logic [LFSR_W-1:0] lfsr_q;
  logic              fb_c;

  assign fb_c = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  // LFSR state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_q[LFSR_W-2:0], fb_c};
    end
  end

  assign stall_o = (lfsr_q[1:0] == 2'b00);

endmodule

// File: rtl/obi_mem_responder.sv
// Single-bank word-organised OBI memory responder with fixed read latency.
// Ports: clk_i, rst_i (sync, active-high), bus (slave modport: req_i,
// resp_o, err_o). Parameters: BASE_ADDR, NUM_WORDS (power of two, >= 2),
// LATENCY (1..4). Define OBI_MEM_RESPONDER_RANDOM_STALL_EN to enable
// pseudo-random grant stalls.
module obi_mem_responder
  import obi_mem_responder_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h2001_0000,
  parameter int unsigned       NUM_WORDS = 1024,
  parameter int unsigned       LATENCY   = 1
)
(
  input  logic                clk_i,
  input  logic                rst_i,
  obi_mem_responder_if.slave  bus
);

  localparam int unsigned       IDX_W = $clog2(NUM_WORDS);
  localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(NUM_WORDS * 4);

  logic                stall_c;
  logic                gnt_c;
  logic [ADDR_W-1:0]   off_c;
  logic                in_range_c;
  logic [IDX_W-1:0]    idx_c;
  resp_stage_t         new_stage_c;
  logic                rvalid_c;

  logic [DATA_W-1:0]   mem_q   [NUM_WORDS];
  resp_stage_t         stage_q [LATENCY];

  // Grant-stall source
`ifdef OBI_MEM_RESPONDER_RANDOM_STALL_EN
  obi_mem_responder_lfsr u_lfsr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .stall_o (stall_c)
  );
`else
  assign stall_c = 1'b0;
`endif

  assign gnt_c = bus.req_i.req & ~stall_c & ~rst_i;

  // Address decode; wrap-around makes addresses below BASE_ADDR out of range
  assign off_c      = bus.req_i.addr - BASE_ADDR;
  assign in_range_c = (off_c < SPAN);
  assign idx_c      = off_c[2 +: IDX_W];

  // Byte-enabled storage, deliberately without reset
  always_ff @(posedge clk_i) begin
    if (gnt_c && bus.req_i.we && in_range_c) begin
      for (int unsigned i = 0; i < BE_W; i++) begin
        if (bus.req_i.be[i]) begin
          mem_q[idx_c][8*i +: 8] <= bus.req_i.wdata[8*i +: 8];
        end
      end
    end
  end

  // Response entering the pipeline at the grant edge
  always_comb begin
    new_stage_c       = '0;
    new_stage_c.valid = gnt_c;
    new_stage_c.err   = gnt_c & ~in_range_c;
    if (gnt_c) begin
      if (!in_range_c) begin
        new_stage_c.rdata = bus.req_i.we ? '0 : RD_ERR_PATTERN;
      end else if (!bus.req_i.we) begin
        new_stage_c.rdata = mem_q[idx_c];
      end
    end
  end

  // Fixed-depth response pipeline; reset drops everything in flight
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= new_stage_c;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  // Outputs are masked while reset is held so nothing leaks during reset
  assign rvalid_c = stage_q[LATENCY-1].valid & ~rst_i;

  always_comb begin
    bus.resp_o        = '0;
    bus.resp_o.gnt    = gnt_c;
    bus.resp_o.rvalid = rvalid_c;
    bus.resp_o.rdata  = rvalid_c ? stage_q[LATENCY-1].rdata : '0;
    bus.err_o         = rvalid_c & stage_q[LATENCY-1].err;
  end

endmodule

// File: tb/tb_obi_mem_responder.sv
// Directed testbench for obi_mem_responder: three instances with latency 1,
// 3 and 4, exercised through scenario tasks with hand-computed expectations.
module tb_obi_mem_responder;
  import obi_mem_responder_pkg::*;

  localparam logic [31:0] BASE = 32'h2001_0000;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  obi_mem_responder_if bus1 ();
  obi_mem_responder_if bus3 ();
  obi_mem_responder_if bus4 ();

  obi_mem_responder #(.BASE_ADDR(BASE), .NUM_WORDS(1024), .LATENCY(1)) u_dut1 (
    .clk_i (clk), .rst_i (rst), .bus (bus1.slave)
  );
  obi_mem_responder #(.BASE_ADDR(BASE), .NUM_WORDS(16), .LATENCY(3)) u_dut3 (
    .clk_i (clk), .rst_i (rst), .bus (bus3.slave)
  );
  obi_mem_responder #(.BASE_ADDR(BASE), .NUM_WORDS(16), .LATENCY(4)) u_dut4 (
    .clk_i (clk), .rst_i (rst), .bus (bus4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drv(input int d, input logic rq, input logic we_v, input logic [3:0] be_v,
                     input logic [31:0] addr_v, input logic [31:0] wdata_v);
    obi_req_t r;
    r.req   = rq;
    r.we    = we_v;
    r.be    = be_v;
    r.addr  = addr_v;
    r.wdata = wdata_v;
    case (d)
      1:       bus1.req_i = r;
      3:       bus3.req_i = r;
      default: bus4.req_i = r;
    endcase
  endtask

  // {rvalid, err, rdata} of one instance
  function automatic logic [33:0] obs(input int d);
    case (d)
      1:       return {bus1.resp_o.rvalid, bus1.err_o, bus1.resp_o.rdata};
      3:       return {bus3.resp_o.rvalid, bus3.err_o, bus3.resp_o.rdata};
      default: return {bus4.resp_o.rvalid, bus4.err_o, bus4.resp_o.rdata};
    endcase
  endfunction

  function automatic logic gnt(input int d);
    case (d)
      1:       return bus1.resp_o.gnt;
      3:       return bus3.resp_o.gnt;
      default: return bus4.resp_o.gnt;
    endcase
  endfunction

  task automatic test_reset();
    logic [33:0] got;
    logic        g;
    rst = 1'b1;
    drv(1, 1'b1, 1'b0, 4'h0, BASE, 32'h0);
    drv(3, 1'b0, 1'b0, 4'h0, BASE, 32'h0);
    drv(4, 1'b0, 1'b0, 4'h0, BASE, 32'h0);
    repeat (3) @(negedge clk);
    #1;
    n_checks++; g = gnt(1);
    if (g !== 1'b0) begin n_fail++; $display("FAIL rst_gnt: got %b exp 0", g); end
    n_checks++; got = obs(1);
    if (got !== 34'h0) begin n_fail++; $display("FAIL rst_resp_d1: got %h exp %h", got, 34'h0); end
    n_checks++; got = obs(3);
    if (got !== 34'h0) begin n_fail++; $display("FAIL rst_resp_d3: got %h exp %h", got, 34'h0); end
    n_checks++; got = obs(4);
    if (got !== 34'h0) begin n_fail++; $display("FAIL rst_resp_d4: got %h exp %h", got, 34'h0); end
    @(negedge clk);
    rst = 1'b0;
    drv(1, 1'b0, 1'b0, 4'h0, BASE, 32'h0);
    #1;
    n_checks++; got = obs(1);
    if (got !== 34'h0) begin n_fail++; $display("FAIL post_rst_d1: got %h exp %h", got, 34'h0); end
  endtask

  task automatic test_write_read();
    logic [33:0] got;
    logic        g;
    @(negedge clk);
    drv(1, 1'b1, 1'b1, 4'hF, BASE + 32'h10, 32'hDEAD_BEEF);
    #1;
    n_checks++; g = gnt(1);
    if (g !== 1'b1) begin n_fail++; $display("FAIL wr_gnt: got %b exp 1", g); end
    @(negedge clk);
    n_checks++; got = obs(1);
    if (got !== {1'b1, 1'b0, 32'h0}) begin n_fail++; $display("FAIL wr_resp: got %h exp %h", got, {1'b1, 1'b0, 32'h0}); end
    drv(1, 1'b1, 1'b0, 4'h0, BASE + 32'h13, 32'h0);
    @(negedge clk);
    n_checks++; got = obs(1);
    if (got !== {1'b1, 1'b0, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL raw_read: got %h exp %h", got, {1'b1, 1'b0, 32'hDEAD_BEEF}); end
    drv(1, 1'b0, 1'b0, 4'h0, BASE, 32'h0);
    @(negedge clk);
    n_checks++; got = obs(1);
    if (got !== 34'h0) begin n_fail++; $display("FAIL one_rvalid: got %h exp %h", got, 34'h0); end
  endtask

  task automatic test_partial_write();
    logic [33:0] got;
    @(negedge clk);
    drv(1, 1'b1, 1'b1, 4'b0101, BASE + 32'h10, 32'h1122_3344);
    @(negedge clk);
    n_checks++; got = obs(1);
    if (got !== {1'b1, 1'b0, 32'h0}) begin n_fail++; $display("FAIL pw_resp: got %h exp %h", got, {1'b1, 1'b0, 32'h0}); end
    drv(1, 1'b0, 1'b0, 4'h0, BASE, 32'h0);
    @(negedge clk);
    drv(1, 1'b1, 1'b0, 4'h0, BASE + 32'h10, 32'h0);
    @(negedge clk);
    n_checks++; got = obs(1);
    if (got !== {1'b1, 1'b0, 32'hDE22_BE44}) begin n_fail++; $display("FAIL pw_read: got %h exp %h", got, {1'b1, 1'b0, 32'hDE22_BE44}); end
    drv(1, 1'b0, 1'b0, 4'h0, BASE, 32'h0);
  endtask

  task automatic test_out_of_range();
    logic [33:0] got;
    @(negedge clk);
    drv(1, 1'b1, 1'b1, 4'hF, BASE + 32'hFFC, 32'hAABB_CCDD);
    @(negedge clk);
    drv(1, 1'b1, 1'b0, 4'h0, BASE + 32'h1000, 32'h0);
    @(negedge clk);
    n_checks++; got = obs(1);
    if (got !== {1'b1, 1'b1, 32'hBADC_AB1E}) begin n_fail++; $display("FAIL oor_read: got %h exp %h", got, {1'b1, 1'b1, 32'hBADC_AB1E}); end
    drv(1, 1'b1, 1'b1, 4'hF, BASE - 32'h4, 32'h0000_0000);
    @(negedge clk);
    n_checks++; got = obs(1);
    if (got !== {1'b1, 1'b1, 32'h0}) begin n_fail++; $display("FAIL oor_write: got %h exp %h", got, {1'b1, 1'b1, 32'h0}); end
    drv(1, 1'b1, 1'b0, 4'h0, BASE + 32'hFFC, 32'h0);
    @(negedge clk);
    n_checks++; got = obs(1);
    if (got !== {1'b1, 1'b0, 32'hAABB_CCDD}) begin n_fail++; $display("FAIL last_word: got %h exp %h", got, {1'b1, 1'b0, 32'hAABB_CCDD}); end
    drv(1, 1'b0, 1'b0, 4'h0, BASE, 32'h0);
  endtask

  // Latency 3: four writes then four reads on consecutive cycles
  task automatic test_pipelined();
    logic [31:0] pdata [4];
    logic [33:0] got;
    logic [33:0] exp_v;
    int          k;
    pdata[0] = 32'hA0A0_0001;
    pdata[1] = 32'hB1B1_0002;
    pdata[2] = 32'hC2C2_0003;
    pdata[3] = 32'hD3D3_0004;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      k = c - 3;
      if (k >= 0 && k < 4)      exp_v = {1'b1, 1'b0, 32'h0};
      else if (k >= 4 && k < 8) exp_v = {1'b1, 1'b0, pdata[k-4]};
      else                      exp_v = 34'h0;
      n_checks++; got = obs(3);
      if (got !== exp_v) begin n_fail++; $display("FAIL pipe_c%0d: got %h exp %h", c, got, exp_v); end
      if (c < 4)      drv(3, 1'b1, 1'b1, 4'hF, BASE + 32'(c * 4), pdata[c]);
      else if (c < 8) drv(3, 1'b1, 1'b0, 4'h0, BASE + 32'((c - 4) * 4), 32'h0);
      else            drv(3, 1'b0, 1'b0, 4'h0, BASE, 32'h0);
    end
  endtask

  // Latency 4: reset two cycles after a read grant drops the read
  task automatic test_reset_midflight();
    logic [33:0] got;
    logic [33:0] exp_v;
    logic        g;
    @(negedge clk);
    drv(4, 1'b1, 1'b1, 4'hF, BASE + 32'h8, 32'h5A5A_5A5A);
    @(negedge clk);
    drv(4, 1'b1, 1'b0, 4'h0, BASE, 32'h0);
    @(negedge clk);
    drv(4, 1'b0, 1'b0, 4'h0, BASE, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    drv(4, 1'b1, 1'b0, 4'h0, BASE, 32'h0);
    #1;
    n_checks++; g = gnt(4);
    if (g !== 1'b0) begin n_fail++; $display("FAIL mid_rst_gnt: got %b exp 0", g); end
    n_checks++; got = obs(4);
    if (got !== 34'h0) begin n_fail++; $display("FAIL mid_rst_resp: got %h exp %h", got, 34'h0); end
    @(negedge clk);
    rst = 1'b0;
    drv(4, 1'b0, 1'b0, 4'h0, BASE, 32'h0);
    #1;
    n_checks++; got = obs(4);
    if (got !== 34'h0) begin n_fail++; $display("FAIL mid_post_rst: got %h exp %h", got, 34'h0); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++; got = obs(4);
      if (got !== 34'h0) begin n_fail++; $display("FAIL dropped_c%0d: got %h exp %h", c, got, 34'h0); end
    end
    drv(4, 1'b1, 1'b0, 4'h0, BASE + 32'h8, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) drv(4, 1'b0, 1'b0, 4'h0, BASE, 32'h0);
      exp_v = (c == 4) ? {1'b1, 1'b0, 32'h5A5A_5A5A} : 34'h0;
      n_checks++; got = obs(4);
      if (got !== exp_v) begin n_fail++; $display("FAIL committed_c%0d: got %h exp %h", c, got, exp_v); end
    end
  endtask

`ifdef OBI_MEM_RESPONDER_RANDOM_STALL_EN
  // Random traffic on the latency-1 instance against a scoreboard
  task automatic test_random_stall();
    logic [31:0] model [16];
    logic [33:0] expq [$];
    logic [33:0] got;
    logic [33:0] e;
    logic        pend, we_v, oor;
    logic [3:0]  be_v;
    logic [31:0] wd, rdv;
    int          widx, issued, stalls;
    pend = 1'b0; issued = 0; stalls = 0;
    we_v = 1'b0; be_v = 4'h0; wd = 32'h0; widx = 0; oor = 1'b0;
    for (int cyc = 0; cyc < 3000 && !(issued >= 1000 && expq.size() == 0); cyc++) begin
      @(negedge clk);
      got = obs(1);
      if (got[33]) begin
        n_checks++;
        if (expq.size() == 0) begin
          n_fail++; $display("FAIL rnd_spurious: got %h exp no response", got);
        end else begin
          e = expq.pop_front();
          if (got !== e) begin n_fail++; $display("FAIL rnd_data: got %h exp %h", got, e); end
        end
      end
      if (!pend && issued < 1000) begin
        if (issued < 16) begin
          we_v = 1'b1; be_v = 4'hF; widx = issued; oor = 1'b0; wd = $urandom;
        end else begin
          we_v = 1'($urandom_range(1, 0)); be_v = 4'($urandom_range(15, 0));
          wd = $urandom; widx = $urandom_range(16, 0); oor = (widx == 16);
        end
        pend = 1'b1;
        drv(1, 1'b1, we_v, be_v, oor ? BASE + 32'h1000 : BASE + 32'(widx * 4), wd);
      end else if (!pend) begin
        drv(1, 1'b0, 1'b0, 4'h0, BASE, 32'h0);
      end
      #1;
      if (pend && gnt(1)) begin
        if (oor) begin
          rdv = we_v ? 32'h0 : 32'hBADC_AB1E;
        end else if (we_v) begin
          rdv = 32'h0;
          for (int b = 0; b < 4; b++) if (be_v[b]) model[widx][8*b +: 8] = wd[8*b +: 8];
        end else begin
          rdv = model[widx];
        end
        expq.push_back({1'b1, oor, rdv});
        issued++;
        pend = 1'b0;
      end else if (pend) begin
        stalls++;
      end
    end
    drv(1, 1'b0, 1'b0, 4'h0, BASE, 32'h0);
    n_checks++;
    if (issued != 1000 || expq.size() != 0) begin
      n_fail++; $display("FAIL rnd_complete: got issued=%0d pending=%0d exp 1000/0", issued, expq.size());
    end
    n_checks++;
    if (stalls == 0) begin n_fail++; $display("FAIL rnd_stalls: got %0d exp >0", stalls); end
  endtask
`else
  // Without stalls every request is granted in the same cycle
  task automatic test_no_stall();
    logic g;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      drv(1, 1'b1, 1'b0, 4'h0, BASE + 32'(c * 4), 32'h0);
      #1;
      n_checks++; g = gnt(1);
      if (g !== 1'b1) begin n_fail++; $display("FAIL nostall_gnt_c%0d: got %b exp 1", c, g); end
    end
    @(negedge clk);
    drv(1, 1'b0, 1'b0, 4'h0, BASE, 32'h0);
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
`ifdef OBI_MEM_RESPONDER_RANDOM_STALL_EN
    test_random_stall();
`else
    test_write_read();
    test_partial_write();
    test_out_of_range();
    test_pipelined();
    test_reset_midflight();
    test_no_stall();
`endif
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
